// File: rtl/dmem_byte_arbiter.sv
// Two-port word access arbiter for a byte-wide synchronous data memory.
// Each granted word is moved as four little-endian byte beats, then acknowledged.
module dmem_byte_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          beat_r, beat_s;
  logic                last_grant_r, last_grant_s;
  logic                grant_s, win_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic                we_r, we_s;
  logic [31:0]         wdata_r, wdata_s;
  logic [23:0]         asm_r, asm_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [7:0]          mem_wdata_s;
  logic                mem_we_s, mem_re_s;
  logic                ack0_s, ack1_s;
  logic [31:0]         rdata0_r, rdata1_r;
  logic [31:0]         rdword_s;
  logic                rd_ack_s;
  logic                unused_s;

  function automatic logic [7:0] beat_byte(input logic [31:0] word, input logic [1:0] beat);
    case (beat)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return 8'h00;
    endcase
  endfunction

  assign unused_s = ^{addr0_i[31:ADDR_W], addr1_i[31:ADDR_W]};

  // Beat 3's byte arrives in the ACK cycle, so the returned word bypasses the holding register.
  assign rdword_s = {mem_rdata_i, asm_r};
  assign rd_ack_s = (state_r == ST_ACK) && !we_r;
  assign rdata0_o = (rd_ack_s && !grant_o) ? rdword_s : rdata0_r;
  assign rdata1_o = (rd_ack_s &&  grant_o) ? rdword_s : rdata1_r;

  // Next-state, arbitration, beat sequencing and next registered memory strobes.
  always_comb begin
    state_s      = state_r;
    beat_s       = beat_r;
    last_grant_s = last_grant_r;
    grant_s      = grant_o;
    win_s        = 1'b0;
    base_s       = base_r;
    we_s         = we_r;
    wdata_s      = wdata_r;
    asm_s        = asm_r;
    mem_addr_s   = '0;
    mem_wdata_s  = 8'h00;
    mem_we_s     = 1'b0;
    mem_re_s     = 1'b0;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          win_s        = (req0_i && req1_i) ? ~last_grant_r : req1_i;
          grant_s      = win_s;
          last_grant_s = win_s;
          base_s       = win_s ? addr1_i[ADDR_W-1:0] : addr0_i[ADDR_W-1:0];
          we_s         = win_s ? we1_i : we0_i;
          wdata_s      = win_s ? wdata1_i : wdata0_i;
          beat_s       = 2'd0;
          state_s      = ST_XFER;
          mem_addr_s   = base_s;
          mem_we_s     = we_s;
          mem_re_s     = ~we_s;
          mem_wdata_s  = we_s ? wdata_s[7:0] : 8'h00;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        // The byte for beat k-1 is valid while beat k is on the bus.
        if (!we_r) begin
          case (beat_r)
            2'd1:    asm_s[7:0]   = mem_rdata_i;
            2'd2:    asm_s[15:8]  = mem_rdata_i;
            2'd3:    asm_s[23:16] = mem_rdata_i;
            default: asm_s        = asm_r;
          endcase
        end else begin
          asm_s = asm_r;
        end
        if (beat_r == 2'd3) begin
          state_s = ST_ACK;
          ack0_s  = ~grant_o;
          ack1_s  = grant_o;
        end else begin
          beat_s      = beat_r + 2'd1;
          mem_addr_s  = base_r + ADDR_W'(beat_s);
          mem_we_s    = we_r;
          mem_re_s    = ~we_r;
          mem_wdata_s = we_r ? beat_byte(wdata_r, beat_s) : 8'h00;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, transaction context and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      beat_r       <= 2'd0;
      last_grant_r <= 1'b1;
      base_r       <= '0;
      we_r         <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      asm_r        <= 24'h00_0000;
      rdata0_r     <= 32'h0000_0000;
      rdata1_r     <= 32'h0000_0000;
      grant_o      <= 1'b0;
      busy_o       <= 1'b0;
      ack0_o       <= 1'b0;
      ack1_o       <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= 8'h00;
      mem_we_o     <= 1'b0;
      mem_re_o     <= 1'b0;
    end else begin
      state_r      <= state_s;
      beat_r       <= beat_s;
      last_grant_r <= last_grant_s;
      base_r       <= base_s;
      we_r         <= we_s;
      wdata_r      <= wdata_s;
      asm_r        <= asm_s;
      rdata0_r     <= rdata0_o;
      rdata1_r     <= rdata1_o;
      grant_o      <= grant_s;
      busy_o       <= (state_s != ST_IDLE);
      ack0_o       <= ack0_s;
      ack1_o       <= ack1_s;
      mem_addr_o   <= mem_addr_s;
      mem_wdata_o  <= mem_wdata_s;
      mem_we_o     <= mem_we_s;
      mem_re_o     <= mem_re_s;
    end
  end

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Directed self-checking bench for dmem_byte_arbiter with a byte-wide memory model.
module tb_dmem_byte_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy, grant;

  int checks = 0;
  int passes = 0;
  logic hold0 = 1'b0;
  logic hold1 = 1'b0;
  logic bad_strobe = 1'b0;

  logic [7:0]  mem [0:31];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [7:0]  pl_data;

  logic [4:0]  o_addr [0:23];
  logic [7:0]  o_wd   [0:23];
  logic        o_we   [0:23];
  logic        o_re   [0:23];
  logic        o_ack0 [0:23];
  logic        o_ack1 [0:23];
  logic        o_busy [0:23];
  logic        o_grant[0:23];
  logic [31:0] o_rd0  [0:23];
  logic [31:0] o_rd1  [0:23];

  always #5 clk = ~clk;

  dmem_byte_arbiter #(.ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .grant_o(grant)
  );

  // Synchronous byte memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if ((mem_we && mem_re) || ((mem_we || mem_re) && !busy)) bad_strobe <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records n cycles of outputs; requesters drop req on their ack unless held.
  task automatic run_cycles(input int n, input int raise1_at);
    for (int i = 0; i < n; i++) begin
      step();
      o_addr[i] = mem_addr; o_wd[i] = mem_wdata; o_we[i] = mem_we; o_re[i] = mem_re;
      o_ack0[i] = ack0; o_ack1[i] = ack1; o_busy[i] = busy; o_grant[i] = grant;
      o_rd0[i] = rdata0; o_rd1[i] = rdata1;
      if (ack0 && !hold0) req0 = 1'b0;
      if (ack1 && !hold1) req1 = 1'b0;
      if (i == raise1_at) req1 = 1'b1;
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      pl_en = 1'b1; pl_addr = a + 5'(k); pl_data = w[8*k +: 8];
      step();
    end
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) $display("FAIL rst_ack got %b%b exp 00", ack0, ack1); else passes++;
    checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) $display("FAIL rst_rdata got %h %h exp 0 0", rdata0, rdata1); else passes++;
    checks++; if (mem_addr !== 5'd0 || mem_wdata !== 8'h00) $display("FAIL rst_mem got %0d %h exp 0 00", mem_addr, mem_wdata); else passes++;
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) $display("FAIL rst_strobe got %b%b exp 00", mem_we, mem_re); else passes++;
    checks++; if (busy !== 1'b0 || grant !== 1'b0) $display("FAIL rst_busy_grant got %b%b exp 00", busy, grant); else passes++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_write0();
    logic [31:0] wd;
    logic [4:0]  ea;
    wd = 32'hA1B2C3D4;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd8; wdata0 = wd;
    run_cycles(6, -1);
    for (int k = 0; k < 4; k++) begin
      ea = 5'(8 + k);
      checks++; if (o_addr[k] !== ea) $display("FAIL w0_addr[%0d] got %0d exp %0d", k, o_addr[k], ea); else passes++;
      checks++; if (o_wd[k] !== wd[8*k +: 8]) $display("FAIL w0_wdata[%0d] got %h exp %h", k, o_wd[k], wd[8*k +: 8]); else passes++;
      checks++; if (o_we[k] !== 1'b1 || o_re[k] !== 1'b0) $display("FAIL w0_strobe[%0d] got %b%b exp 10", k, o_we[k], o_re[k]); else passes++;
      checks++; if (o_ack0[k] !== 1'b0) $display("FAIL w0_early_ack[%0d] got %b exp 0", k, o_ack0[k]); else passes++;
    end
    checks++; if (o_ack0[4] !== 1'b1 || o_we[4] !== 1'b0) $display("FAIL w0_ack got %b we %b exp 1 0", o_ack0[4], o_we[4]); else passes++;
    checks++; if (o_grant[0] !== 1'b0) $display("FAIL w0_grant got %b exp 0", o_grant[0]); else passes++;
    checks++; if (o_busy[4] !== 1'b1 || o_busy[5] !== 1'b0) $display("FAIL w0_busy got %b%b exp 10", o_busy[4], o_busy[5]); else passes++;
    checks++; if ({mem[11], mem[10], mem[9], mem[8]} !== wd) $display("FAIL w0_mem got %h exp %h", {mem[11], mem[10], mem[9], mem[8]}, wd); else passes++;
  endtask

  task automatic test_read0();
    preload(5'd8, 32'hA1B2C3D4);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8; wdata0 = 32'hFFFF_FFFF;
    run_cycles(6, -1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_re[k] !== 1'b1 || o_we[k] !== 1'b0 || o_wd[k] !== 8'h00) $display("FAIL r0_beat[%0d] got re%b we%b wd%h exp re1 we0 wd00", k, o_re[k], o_we[k], o_wd[k]); else passes++;
    end
    checks++; if (o_rd0[3] !== 32'h0) $display("FAIL r0_early got %h exp 0", o_rd0[3]); else passes++;
    checks++; if (o_ack0[4] !== 1'b1 || o_rd0[4] !== 32'hA1B2C3D4) $display("FAIL r0_data got ack%b %h exp ack1 a1b2c3d4", o_ack0[4], o_rd0[4]); else passes++;
    checks++; if (o_rd1[4] !== 32'h0) $display("FAIL r0_rdata1 got %h exp 0", o_rd1[4]); else passes++;
    checks++; if (o_rd0[5] !== 32'hA1B2C3D4) $display("FAIL r0_hold got %h exp a1b2c3d4", o_rd0[5]); else passes++;
  endtask

  task automatic test_wrap1();
    logic [31:0] wd;
    logic [4:0]  ea;
    wd = 32'h11223344;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'hFFFF_FFFE; wdata1 = wd;
    run_cycles(6, -1);
    for (int k = 0; k < 4; k++) begin
      ea = 5'(30 + k);
      checks++; if (o_addr[k] !== ea || o_wd[k] !== wd[8*k +: 8]) $display("FAIL wr1_beat[%0d] got %0d %h exp %0d %h", k, o_addr[k], o_wd[k], ea, wd[8*k +: 8]); else passes++;
    end
    checks++; if (o_ack1[4] !== 1'b1 || o_ack0[4] !== 1'b0 || o_grant[0] !== 1'b1) $display("FAIL wr1_ack got ack1 %b ack0 %b grant %b exp 1 0 1", o_ack1[4], o_ack0[4], o_grant[0]); else passes++;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd30;
    run_cycles(6, -1);
    for (int k = 0; k < 4; k++) begin
      ea = 5'(30 + k);
      checks++; if (o_addr[k] !== ea || o_re[k] !== 1'b1) $display("FAIL rd1_beat[%0d] got %0d re%b exp %0d re1", k, o_addr[k], o_re[k], ea); else passes++;
    end
    checks++; if (o_ack1[4] !== 1'b1 || o_rd1[4] !== wd) $display("FAIL rd1_data got ack%b %h exp ack1 %h", o_ack1[4], o_rd1[4], wd); else passes++;
    checks++; if (o_rd0[4] !== 32'hA1B2C3D4) $display("FAIL rd1_rdata0 got %h exp a1b2c3d4", o_rd0[4]); else passes++;
  endtask

  task automatic test_tie();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd0; wdata0 = 32'h01020304;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd4; wdata1 = 32'h05060708;
    hold0 = 1'b1;
    run_cycles(17, -1);
    checks++; if (o_grant[0] !== 1'b0 || o_addr[0] !== 5'd0) $display("FAIL tie_first got grant %b addr %0d exp 0 0", o_grant[0], o_addr[0]); else passes++;
    checks++; if (o_ack0[4] !== 1'b1 || o_ack1[4] !== 1'b0) $display("FAIL tie_ack0 got %b%b exp 10", o_ack0[4], o_ack1[4]); else passes++;
    checks++; if (o_grant[6] !== 1'b1 || o_addr[6] !== 5'd4) $display("FAIL tie_second got grant %b addr %0d exp 1 4", o_grant[6], o_addr[6]); else passes++;
    checks++; if (o_ack1[10] !== 1'b1 || o_ack0[10] !== 1'b0) $display("FAIL tie_ack1 got %b%b exp 10", o_ack1[10], o_ack0[10]); else passes++;
    checks++; if (o_grant[12] !== 1'b0 || o_ack0[16] !== 1'b1) $display("FAIL tie_third got grant %b ack0 %b exp 0 1", o_grant[12], o_ack0[16]); else passes++;
    req0 = 1'b0; hold0 = 1'b0;
    run_cycles(1, -1);
    checks++; if (o_busy[0] !== 1'b0) $display("FAIL tie_idle got busy %b exp 0", o_busy[0]); else passes++;
    checks++; if (mem[4] !== 8'h08 || mem[0] !== 8'h04) $display("FAIL tie_mem got %h %h exp 08 04", mem[4], mem[0]); else passes++;
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd0;
    hold0 = 1'b1; hold1 = 1'b1;
    run_cycles(17, -1);
    checks++; if (o_grant[0] !== 1'b1 || o_grant[6] !== 1'b0 || o_grant[12] !== 1'b1) $display("FAIL b2b_grants got %b%b%b exp 101", o_grant[0], o_grant[6], o_grant[12]); else passes++;
    checks++; if (o_ack1[4] !== 1'b1 || o_rd1[4] !== 32'h01020304) $display("FAIL b2b_p1 got ack%b %h exp ack1 01020304", o_ack1[4], o_rd1[4]); else passes++;
    checks++; if (o_ack0[10] !== 1'b1 || o_rd0[10] !== 32'hA1B2C3D4) $display("FAIL b2b_p0 got ack%b %h exp ack1 a1b2c3d4", o_ack0[10], o_rd0[10]); else passes++;
    checks++; if (o_ack1[16] !== 1'b1 || o_ack0[16] !== 1'b0) $display("FAIL b2b_p1b got %b%b exp 10", o_ack1[16], o_ack0[16]); else passes++;
    req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    run_cycles(1, -1);
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd16; wdata0 = 32'hDEADBEEF;
    run_cycles(3, -1);
    checks++; if (o_we[2] !== 1'b1 || o_addr[2] !== 5'd18) $display("FAIL rm_beat2 got we%b %0d exp we1 18", o_we[2], o_addr[2]); else passes++;
    rst = 1'b1; req0 = 1'b0;
    step();
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || ack0 !== 1'b0) $display("FAIL rm_strobe got we%b re%b ack%b exp 000", mem_we, mem_re, ack0); else passes++;
    checks++; if (busy !== 1'b0 || grant !== 1'b0) $display("FAIL rm_busy got %b%b exp 00", busy, grant); else passes++;
    checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) $display("FAIL rm_rdata got %h %h exp 0 0", rdata0, rdata1); else passes++;
    rst = 1'b0;
    run_cycles(2, -1);
    checks++; if (o_we[1] !== 1'b0 || o_ack0[1] !== 1'b0) $display("FAIL rm_quiet got we%b ack%b exp 00", o_we[1], o_ack0[1]); else passes++;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
    run_cycles(6, -1);
    checks++; if (o_ack0[3] !== 1'b0 || o_ack0[4] !== 1'b1 || o_rd0[4] !== 32'hA1B2C3D4) $display("FAIL rm_read got ack%b%b %h exp 01 a1b2c3d4", o_ack0[3], o_ack0[4], o_rd0[4]); else passes++;
  endtask

  task automatic test_overlap();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd20; wdata0 = 32'hCAFEF00D;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd20;
    run_cycles(12, 1);
    for (int k = 1; k < 5; k++) begin
      checks++; if (o_grant[k] !== 1'b0 || o_ack1[k] !== 1'b0) $display("FAIL ov_hold[%0d] got grant %b ack1 %b exp 0 0", k, o_grant[k], o_ack1[k]); else passes++;
    end
    checks++; if (o_ack0[4] !== 1'b1) $display("FAIL ov_ack0 got %b exp 1", o_ack0[4]); else passes++;
    checks++; if (o_grant[6] !== 1'b1 || o_re[6] !== 1'b1 || o_addr[6] !== 5'd20) $display("FAIL ov_p1_start got grant %b re %b addr %0d exp 1 1 20", o_grant[6], o_re[6], o_addr[6]); else passes++;
    checks++; if (o_ack1[10] !== 1'b1 || o_rd1[10] !== 32'hCAFEF00D) $display("FAIL ov_p1_data got ack%b %h exp ack1 cafef00d", o_ack1[10], o_rd1[10]); else passes++;
    checks++; if (o_busy[11] !== 1'b0) $display("FAIL ov_idle got busy %b exp 0", o_busy[11]); else passes++;
    checks++; if (bad_strobe !== 1'b0) $display("FAIL strobe_exclusive got %b exp 0", bad_strobe); else passes++;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    pl_en = 1'b0; pl_addr = 5'd0; pl_data = 8'h00;
    test_reset();
    test_write0();
    test_read0();
    test_wrap1();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_overlap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_byte_arbiter.md
# dmem_byte_arbiter

Arbitrates and sequences 32-bit word accesses from two requesters (CPU data port 0, DMA/test-loader port 1) onto a single byte-wide synchronous data memory. Each granted word access is split into four little-endian byte beats. Read bytes are reassembled into a word and returned to the winning requester with a one-cycle acknowledge. The block sits between the MEM pipeline stage (plus the loader) and the data memory array, and is the only master of that array.

## Interface
- ADDR_W, 5, byte-address width of the memory; depth is 2^ADDR_W bytes; byte addresses wrap modulo 2^ADDR_W.
- clk_i  in  1  single clock; everything is sampled on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req0_i / req1_i  in  1  access request from port 0 / port 1; held high until that port's ack.
- we0_i / we1_i  in  1  1 = write word, 0 = read word; stable while req is high.
- addr0_i / addr1_i  in  32  byte address; only bits [ADDR_W-1:0] are used.
- wdata0_i / wdata1_i  in  32  write data; stable while req is high.
- ack0_o / ack1_o  out  1  one-cycle pulse when the port's access completes.
- rdata0_o / rdata1_o  out  32  read word; updated only at that port's read ack, held otherwise.
- mem_addr_o  out  ADDR_W  byte address to memory.
- mem_wdata_o  out  8  write byte.
- mem_we_o  out  1  byte write strobe.
- mem_re_o  out  1  byte read strobe; mem_rdata_i is valid exactly one cycle later.
- mem_rdata_i  in  8  read byte from memory.
- busy_o  out  1  high in every state except IDLE.
- grant_o  out  1  index of the currently or most recently granted port.

## Operation
- States:
  - IDLE: no transaction in progress.
  - XFER: four beats, beat counter 0..3.
  - ACK: one cycle.
- Transitions: IDLE→XFER when any req is high; XFER→ACK after beat 3; ACK→IDLE always.
- Arbitration happens in IDLE only.
  - A single requester wins directly.
  - If both request, round-robin applies: the port not granted last wins.
  - The last-grant register resets to 1, so port 0 wins the first tie.
  - grant_o shows the winner.
- On grant, the block latches addr[ADDR_W-1:0], we and wdata of the winner. Requester inputs are ignored until the next IDLE.
- Beat k (k = 0..3):
  - mem_addr_o = (base + k) mod 2^ADDR_W.
  - Write: mem_we_o = 1, mem_wdata_o = wdata[8k+7:8k].
  - Read: mem_re_o = 1, mem_wdata_o = 0.
- Read data: the byte returned for beat k lands in the assembly register bits [8k+7:8k], one cycle after beat k's strobe. Beat 3's byte is captured in the ACK cycle.
- ACK cycle: ack of the granted port = 1. For reads, rdata of that port is loaded with the assembled word, including beat 3's byte, and is visible in the same cycle. Writes leave rdata unchanged.
- The losing or new requester waits; its req stays high and is evaluated at the next IDLE.
- No alignment requirement. Unaligned and wrapping addresses are legal, e.g. base 30 touches bytes 30, 31, 0, 1.

## Timing
- Reset: state IDLE; every output 0 (ack*, rdata*, mem_*, busy_o, grant_o); assembly register 0; last-grant register 1.
- A req first seen high in IDLE at cycle T gives:
  - beats 0..3 in cycles T+1..T+4;
  - ack at T+5;
  - IDLE at T+6.
  - Latency from req to ack is 5 cycles, occupancy is 6 cycles per access.
- The requester must drop req in the cycle after its ack. If req is still high at T+6, it is treated as a new access.
- mem_we_o and mem_re_o are never high together, and both are low outside XFER.
- Back-to-back contention alternates grants: 0, 1, 0, ... with 6 cycles per access.
- Reset mid-transaction:
  - returns to IDLE at the next edge;
  - strobes drop with no further beats;
  - no ack is issued;
  - memory may hold a partial write, which is acceptable;
  - rdata* clear to 0.

## Test plan
- Reset, then port 0 writes 0xA1B2C3D4 at address 8 → beats at addr 8..11 with wdata 0xD4, 0xC3, 0xB2, 0xA1; ack0 exactly 5 cycles after req0 is first sampled.
- Port 0 reads address 8 with the memory model preloaded → rdata0_o = 0xA1B2C3D4 in the ack cycle; rdata1_o stays 0.
- Port 1 writes 0x11223344 at address 30, then reads it → mem_addr sequence 30, 31, 0, 1; rdata1_o = 0x11223344.
- req0 and req1 rise in the same cycle, both held → port 0 is served first (ack0 at T+5), port 1 next (ack1 at T+11); a repeated tie goes to port 1 first.
- rst_i asserted during beat 2 of a write → mem_we_o low the next cycle, no ack, busy_o 0; a following read completes normally.
- Port 0 write in progress while req1 rises → port 1 is not granted until IDLE; mem_we_o and mem_re_o are never high simultaneously throughout.
